arbiter8_rr: RTL and testbench

ARBITER8_RR -- requirements
Module: arbiter8_rr

---
 rtl/arbiter8_rr.sv | 136 +++++++++++++
 tb/tb_arbiter8_rr.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/arbiter8_rr.sv
// Eight-way round-robin arbiter with a bounded hold time and a timeout pulse.
// "release" is a reserved word, so the holder's done strobe is the port rel.
module arbiter8_rr #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam int unsigned N_REQ  = 8;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [CNT_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]  hold_cnt_nxt;
  logic [N_REQ-1:0]  gnt_nxt;
  logic [ID_W-1:0]   gnt_id_nxt;
  logic              busy_nxt;
  logic              timeout_nxt;

  logic [ID_W-1:0]   winner;
  logic              any_req;
  logic              e_rel;
  logic              e_drop;
  logic              e_hold;
  logic              grant_exit;

  // First requester at or above ptr, wrapping 7 -> 0.
  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < int'(N_REQ); k++) begin
      idx = ptr + ID_W'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_req    = |req;
  assign e_rel      = rel;
  assign e_drop     = ~req[gnt_id];
  assign e_hold     = (hold_cnt == HOLD_LAST);
  assign grant_exit = e_rel | e_drop | e_hold;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_cnt_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= gnt_id_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)    state_nxt = GRANT;
      GRANT:   if (grant_exit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    gnt_nxt      = gnt;
    gnt_id_nxt   = gnt_id;
    busy_nxt     = busy;
    timeout_nxt  = 1'b0;
    ptr_nxt      = ptr;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nxt      = N_REQ'(1) << winner;
          gnt_id_nxt   = winner;
          busy_nxt     = 1'b1;
          hold_cnt_nxt = '0;
        end else begin
          gnt_nxt  = '0;
          busy_nxt = 1'b0;
        end
      end
      GRANT: begin
        if (grant_exit) begin
          gnt_nxt     = '0;
          busy_nxt    = 1'b0;
          ptr_nxt     = gnt_id + ID_W'(1);
          // A release or a dropped request wins over the hold limit.
          timeout_nxt = e_hold & ~e_rel & ~e_drop;
        end else if (hold_cnt != CNT_MAX) begin
          hold_cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arbiter8_rr.sv
// Bench for arbiter8_rr: directed scenarios plus random traffic against a behavioural model.
module tb_arbiter8_rr;

  localparam int unsigned MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: busy flag, holder, scan start, visible grant cycles so far, timeout pulse.
  bit m_busy;
  int m_id;
  int m_ptr;
  int m_cyc;
  bit m_to;

  arbiter8_rr #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input logic [7:0] q, input bit d);
    bit e1, e2, e3;
    if (r) begin
      m_busy = 0; m_id = 0; m_ptr = 0; m_cyc = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      if (q != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (q[(m_ptr + k) % 8]) begin
            m_id = (m_ptr + k) % 8;
            break;
          end
        end
        m_busy = 1;
        m_cyc  = 1;
      end
    end else begin
      e1 = d;
      e2 = !q[m_id];
      e3 = (m_cyc == int'(MH));
      if (e1 || e2 || e3) begin
        m_busy = 0;
        m_ptr  = (m_id + 1) % 8;
        m_to   = e3 && !e1 && !e2;
      end else begin
        m_cyc++;
        m_to = 0;
      end
    end
  endfunction

  // Apply inputs, take one edge, advance the model, compare just after the edge.
  task automatic tick(input bit r, input logic [7:0] q, input bit d);
    logic [7:0] eg;
    rst = r; req = q; rel = d;
    @(posedge clk);
    model_step(r, q, d);
    #1;
    eg = m_busy ? (8'h01 << m_id) : 8'h00;
    check("gnt",     32'(gnt),     32'(eg));
    check("gnt_id",  32'(gnt_id),  32'(m_id));
    check("busy",    32'(busy),    32'(m_busy));
    check("timeout", 32'(timeout), 32'(m_to));
    check("onehot",  32'((gnt & (gnt - 8'd1)) == 8'h00), 32'd1);
    if (busy) check("decode", 32'(gnt), 32'(8'h01 << gnt_id));
  endtask

  task automatic do_reset();
    tick(1, 8'h00, 0);
    tick(1, 8'h00, 0);
  endtask

  initial begin
    logic [7:0] rq;
    logic [7:0] seen;
    int         grants;

    // Scenario 1: reset state and idle with no requests.
    do_reset();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_id",  32'(gnt_id), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 8'h00, 0);
      check("s1_idle", 32'({gnt, busy, timeout}), 32'h0);
    end

    // Scenario 2: two requesters, release hands over to the next.
    tick(0, 8'h24, 0);
    check("s2_gnt_a", 32'(gnt), 32'h04);
    check("s2_id_a",  32'(gnt_id), 32'd2);
    tick(0, 8'h24, 1);
    check("s2_drop",  32'(gnt), 32'h00);
    tick(0, 8'h24, 0);
    check("s2_gnt_b", 32'(gnt), 32'h20);
    check("s2_id_b",  32'(gnt_id), 32'd5);

    // Scenario 3: grant to 7, release, then wrap to 0.
    tick(0, 8'h80, 1);
    tick(0, 8'h80, 0);
    check("s3_id7", 32'(gnt_id), 32'd7);
    tick(0, 8'h81, 1);
    tick(0, 8'h81, 0);
    check("s3_wrap_gnt", 32'(gnt), 32'h01);
    check("s3_wrap_id",  32'(gnt_id), 32'd0);

    // Scenario 4: hold limit revokes the grant with a timeout pulse.
    do_reset();
    for (int i = 0; i < int'(MH); i++) begin
      tick(0, 8'h08, 0);
      check("s4_held", 32'({gnt, timeout}), 32'({8'h08, 1'b0}));
    end
    tick(0, 8'h08, 0);
    check("s4_revoke", 32'({gnt, timeout}), 32'({8'h00, 1'b1}));
    tick(0, 8'h08, 0);
    check("s4_regrant", 32'({gnt, timeout}), 32'({8'h08, 1'b0}));

    // Scenario 5: release on the last allowed cycle is a plain release.
    do_reset();
    for (int i = 0; i < int'(MH); i++) tick(0, 8'h08, 0);
    tick(0, 8'h08, 1);
    check("s5_drop", 32'({gnt, busy, timeout}), 32'h0);

    // Scenario 6: reset mid-grant, then arbitration restarts at 0.
    do_reset();
    tick(0, 8'h10, 0);
    tick(0, 8'h10, 0);
    check("s6_held", 32'(gnt), 32'h10);
    tick(1, 8'h11, 0);
    check("s6_rst", 32'({gnt, gnt_id, busy, timeout}), 32'h0);
    tick(0, 8'h11, 0);
    check("s6_first", 32'(gnt_id), 32'd0);

    // Round robin: with all requesting, 8 consecutive grants cover everyone.
    do_reset();
    seen = 8'h00;
    grants = 0;
    for (int i = 0; i < 400 && grants < 8; i++) begin
      tick(0, 8'hFF, ($urandom_range(0, 2) == 0));
      if (m_busy && m_cyc == 1) begin
        seen[m_id] = 1'b1;
        grants++;
      end
    end
    check("rr_grants", 32'(grants), 32'd8);
    check("rr_cover",  32'(seen), 32'hFF);

    // Random traffic with sticky requests, stray releases and rare resets.
    do_reset();
    rq = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       rq = 8'h00;
          1:       rq = 8'hFF;
          default: rq = 8'($urandom);
        endcase
      end
      tick(($urandom_range(0, 63) == 0), rq, ($urandom_range(0, 4) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
